jpeg_byte_stuffer: RTL and testbench

- Sits directly downstream of the 64-coefficient packing stage. That stage presents a 512-bit word of entropy-coded bits, left-aligned and byte-padded.
- This block accepts one packed block plus its valid byte count over a valid/ready handshake.
- It serialises the block MSB-byte-first onto an 8-bit stream and inserts the JPEG stuffing byte 0x00 after every 0xFF data byte.
- It feeds the output bitstream writer.

---
 rtl/jpeg_byte_stuffer.sv | 71 +++++++
 tb/tb_jpeg_byte_stuffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/jpeg_byte_stuffer.sv
// jpeg_byte_stuffer: serialises a packed block MSB-byte-first, inserting 0x00 after each 0xFF.
module jpeg_byte_stuffer #(
  parameter int NUM_BYTES = 64,
  parameter bit STUFF_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_BYTES-1:0] blk_data,
  input  logic [6:0]             blk_bytes,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   blk_done,
  output logic [15:0]            stuff_cnt
);
  localparam int W = 8 * NUM_BYTES;
  localparam logic [6:0] MAX_BYTES = 7'(NUM_BYTES);
  typedef enum logic [1:0] {IDLE, SEND, STUFF} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [6:0]    rem_q, rem_d;
  logic [15:0]   stuff_cnt_q, stuff_cnt_d;
  logic [7:0]    top_byte;
  logic          xfer;
  always_comb begin
    top_byte    = shreg_q[W-1 -: 8];
    blk_ready   = state_q == IDLE;
    out_valid   = state_q != IDLE;
    out_data    = state_q == SEND ? top_byte : 8'h00;
    xfer        = out_valid && out_ready;
    blk_done    = 1'b0;
    state_d     = state_q;
    shreg_d     = shreg_q;
    rem_d       = rem_q;
    stuff_cnt_d = stuff_cnt_q;
    if (state_q == IDLE) begin
      if (blk_valid) begin
        shreg_d = blk_data;
        rem_d   = blk_bytes > MAX_BYTES ? MAX_BYTES : blk_bytes;
        state_d = blk_bytes == 7'd0 ? IDLE : SEND;
      end
    end else if (xfer) begin
      // a 0xFF holds its position until the stuff byte has gone out behind it
      if (state_q == SEND && STUFF_EN && top_byte == 8'hFF) begin
        state_d = STUFF;
      end else begin
        shreg_d  = shreg_q << 8;
        rem_d    = rem_q - 7'd1;
        blk_done = rem_q == 7'd1;
        state_d  = rem_q == 7'd1 ? IDLE : SEND;
        if (state_q == STUFF) stuff_cnt_d = &stuff_cnt_q ? stuff_cnt_q : stuff_cnt_q + 16'd1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      rem_q       <= '0;
      stuff_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      stuff_cnt_q <= stuff_cnt_d;
    end
  end
  assign stuff_cnt = stuff_cnt_q;
endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// tb_jpeg_byte_stuffer: table, directed and random checks of both stuffing modes against a queue model.
module tb_jpeg_byte_stuffer;
  localparam int NB = 64;
  localparam int W  = 8 * NB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [W-1:0] blk_data;
  logic [6:0]   blk_bytes;
  logic         bv0, bv1, or0, or1, br0, br1, ov0, ov1, bd0, bd1;
  logic [7:0]   od0, od1;
  logic [15:0]  sc0, sc1;
  jpeg_byte_stuffer #(.NUM_BYTES(NB), .STUFF_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .blk_data(blk_data), .blk_bytes(blk_bytes), .blk_valid(bv0),
    .blk_ready(br0), .out_data(od0), .out_valid(ov0), .out_ready(or0), .blk_done(bd0), .stuff_cnt(sc0));
  jpeg_byte_stuffer #(.NUM_BYTES(NB), .STUFF_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .blk_data(blk_data), .blk_bytes(blk_bytes), .blk_valid(bv1),
    .blk_ready(br1), .out_data(od1), .out_valid(ov1), .out_ready(or1), .blk_done(bd1), .stuff_cnt(sc1));
  int n_chk = 0;
  int n_fail = 0;
  int exp_stuff[2];
  typedef struct {
    logic [W-1:0] data;
    logic [6:0]   bytes;
    int           sel;
    int           exp_len;
    int           exp_delta;
  } vec_t;
  vec_t tbl[7];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input int sel, input logic v, input logic r);
    bv0 = sel == 0 ? v : 1'b0;
    or0 = sel == 0 ? r : 1'b0;
    bv1 = sel == 1 ? v : 1'b0;
    or1 = sel == 1 ? r : 1'b0;
  endtask
  // rmode: 0 always ready, 1 random ready, 2 ready pattern 0,0,1,0,1 then 1
  task automatic run_block(input int sel, input logic [W-1:0] data, input logic [6:0] bytes,
                           input int rmode, input string tag, input int exp_len, input int exp_delta);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] b, od, prev_d;
    logic [4:0] pat;
    logic       ov, bd, rr, stall_prev;
    int n, dones, done_at, first, last, viol, cyc, fails0, sc_before;
    pat = 5'b10100;
    n = bytes > NB ? NB : int'(bytes);
    sc_before = sel == 0 ? int'(sc0) : int'(sc1);
    for (int i = 0; i < n; i++) begin
      b = data[W-1-8*i -: 8];
      exp_q.push_back(b);
      if (sel == 0 && b == 8'hFF) begin
        exp_q.push_back(8'h00);
        if (exp_stuff[0] < 65535) exp_stuff[0]++;
      end
    end
    blk_data = data;
    blk_bytes = bytes;
    drive(sel, 1'b1, 1'b0);
    @(negedge clk);
    check({tag, " blk_ready_idle"}, sel == 0 ? br0 : br1, 1);
    @(posedge clk); #1;
    dones = 0; done_at = -1; first = -1; last = -1; viol = 0; stall_prev = 1'b0; prev_d = 8'h00; cyc = 0;
    while (cyc < 600) begin
      if (rmode == 0) rr = 1'b1;
      else if (rmode == 1) rr = 1'($urandom_range(0, 1));
      else rr = cyc < 5 ? pat[cyc] : 1'b1;
      drive(sel, 1'b0, rr);
      @(negedge clk);
      ov = sel == 0 ? ov0 : ov1;
      od = sel == 0 ? od0 : od1;
      bd = sel == 0 ? bd0 : bd1;
      if (stall_prev && (!ov || od !== prev_d)) viol++;
      if (bd && !(ov && rr)) viol++;
      if (ov && rr) begin
        got_q.push_back(od);
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (bd) begin
        dones++;
        done_at = got_q.size();
      end
      stall_prev = ov && !rr;
      prev_d = od;
      @(posedge clk); #1;
      cyc++;
      if (dones > 0 || (n == 0 && cyc == 4)) break;
    end
    drive(sel, 1'b0, 1'b0);
    @(negedge clk);
    check({tag, " blk_ready_after"}, sel == 0 ? br0 : br1, 1);
    check({tag, " out_valid_after"}, sel == 0 ? ov0 : ov1, 0);
    check({tag, " stream_len"}, got_q.size(), exp_q.size());
    if (exp_len >= 0) check({tag, " table_len"}, got_q.size(), exp_len);
    fails0 = n_fail;
    for (int i = 0; i < got_q.size() && i < exp_q.size() && n_fail == fails0; i++)
      check($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, " done_count"}, dones, n > 0 ? 1 : 0);
    if (n > 0) check({tag, " done_position"}, done_at, exp_q.size());
    check({tag, " stuff_cnt"}, sel == 0 ? sc0 : sc1, exp_stuff[sel]);
    if (exp_delta >= 0) check({tag, " stuff_delta"}, (sel == 0 ? int'(sc0) : int'(sc1)) - sc_before, exp_delta);
    check({tag, " handshake_violations"}, viol, 0);
    if (rmode == 0 && n > 0) begin
      check({tag, " first_latency"}, first, 0);
      check({tag, " last_cycle"}, last, exp_q.size() - 1);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    logic [W-1:0] d;
    exp_stuff[0] = 0;
    exp_stuff[1] = 0;
    blk_data = '0;
    blk_bytes = '0;
    drive(0, 1'b0, 1'b0);
    #2;
    check("reset blk_ready", br0, 1);
    check("reset out_valid", ov0, 0);
    check("reset out_data", od0, 0);
    check("reset blk_done", bd0, 0);
    check("reset stuff_cnt", sc0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    d = {8'h12, 8'h34, 8'h56, {61{8'hAA}}};
    tbl[0] = '{d, 7'd3, 0, 3, 0};
    d = {8'h01, 8'hFF, 8'h02, {61{8'h00}}};
    tbl[1] = '{d, 7'd3, 0, 4, 1};
    tbl[2] = '{d, 7'd3, 1, 3, 0};
    d = {8'hFF, 8'hFF, {62{8'h00}}};
    tbl[3] = '{d, 7'd2, 0, 4, 2};
    d = {64{8'h5A}};
    tbl[4] = '{d, 7'd0, 0, 0, 0};
    for (int i = 0; i < NB; i++) d[W-1-8*i -: 8] = 8'(i);
    tbl[5] = '{d, 7'd100, 0, 64, 0};
    d = {64{8'hFF}};
    tbl[6] = '{d, 7'd64, 0, 128, 64};
    for (int t = 0; t < 7; t++)
      run_block(tbl[t].sel, tbl[t].data, tbl[t].bytes, 0, $sformatf("tbl%0d", t), tbl[t].exp_len, tbl[t].exp_delta);
    d = {8'hA1, 8'hB2, {62{8'hFF}}};
    run_block(0, d, 7'd2, 2, "backpressure", 2, 0);
    d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, {59{8'hFF}}};
    blk_data = d;
    blk_bytes = 7'd5;
    drive(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("midreset out_data_before", od0, 8'h33);
    rst = 1'b1;
    #1;
    check("midreset out_valid_async", ov0, 0);
    check("midreset blk_done_async", bd0, 0);
    check("midreset stuff_cnt_async", sc0, 0);
    exp_stuff[0] = 0;
    exp_stuff[1] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0);
    @(negedge clk);
    check("midreset blk_ready_release", br0, 1);
    check("midreset out_valid_release", ov0, 0);
    @(posedge clk); #1;
    d = {8'h66, 8'h77, {62{8'hAA}}};
    run_block(0, d, 7'd2, 0, "after_reset", 2, 0);
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NB; i++)
        d[W-1-8*i -: 8] = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom);
      run_block(int'($urandom_range(0, 1)), d, 7'($urandom_range(0, 100)), 1, $sformatf("rand%0d", r), -1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
